matrix_mult_unit: RTL
=====================

Name: matrix_mult_unit

Overview:
Downstream compute stage of the execution engine. It receives two 4x4 operand matrices over the engine's 256-bit module bus, multiplies them (A x B) with one output element per clock, and returns the product with a one-cycle completion flag. Scalar scaling runs through the same path: the engine supplies a diagonal scalar matrix as operand B.

Parameters:
DATA_W, 16, width of one matrix element (unsigned)
DIM, 4, matrix dimension (rows = cols)
MAT_W, DIM*DIM*DATA_W (256), bus width; derived, not overridden

Ports:
clk  input  1  system clock, all logic on posedge
RESET  input  1  synchronous, active-high reset
enable  input  1  request strobe from engine (level; held until fleg seen)
RW  input  1  1 = write operand, 0 = compute and read product
matDecide  input  1  operand select on write: 0 = A, 1 = B
dataInBus  input  MAT_W  operand matrix; element [i][j] at bits i*64+j*16 +:16
dataOut  output  MAT_W  product matrix, same packing
fleg  output  1  one-cycle completion pulse for every accepted request
busy  output  1  high from acceptance until fleg cycle inclusive

Behaviour:
- Reset (RESET high at posedge): state IDLE; dataOut=0, fleg=0, busy=0, operand regs A=B=0, internal accumulator and index=0. Reset mid-operation aborts the request: no fleg, dataOut stays 0.
- States: IDLE, LOAD, COMP, DONE, HOLD.
- IDLE: enable=1 sampled -> accept. RW=1 -> LOAD; RW=0 -> COMP with idx=0. busy=1 from the next cycle.
- LOAD (1 cycle): dataInBus captured into A (matDecide=0) or B (matDecide=1) at the accepting edge. fleg=1 in LOAD, then -> HOLD. Write latency: fleg high in the cycle after acceptance.
- COMP: 16 cycles, idx 0..15, row=idx/4, col=idx%4. Each cycle computes C[row][col] = sum over k of A[row][k]*B[k][col] into the accumulator. Each product and the sum are truncated modulo 2^16. idx=15 -> DONE.
- DONE (1 cycle): dataOut <= accumulator (whole matrix updated at once, never partially), fleg=1, busy=1, then -> HOLD. Read latency: fleg high 17 cycles after the accepting edge.
- HOLD: busy=0, fleg=0. Stays until enable=0 is sampled, then -> IDLE. A level-held enable therefore never triggers a second operation.
- Inputs (dataInBus, RW, matDecide, enable) are ignored outside IDLE.
- dataOut holds its value until the next completed read. Writes never change dataOut. Operands persist across reads, so reading twice with no new write returns the same product.

Decomposition:
- Shared package mat_pkg: DATA_W, DIM, MAT_W constants; state enum typedef; element-slice helper function elem(mat,row,col).
- Sub-module mat_dot4: combinational 4-lane multiply-add (row vector x column vector -> 16-bit truncated sum), instantiated once and muxed by idx.

Test Plan:
- Reset then idle: dataOut=0, fleg=0, busy=0 for 5 cycles; RESET high with enable=1 -> no acceptance.
- Write A = elements 1..16 row-major (A[0][0]=1, A[3][3]=16), write B = same, read -> fleg exactly 17 cycles after read acceptance; C[0][0]=90, C[0][1]=100, C[3][3]=600.
- Write A = arbitrary, B = identity, read -> dataOut == A. Then B = diag(3) -> dataOut == 3*A elementwise.
- Overflow: all A = 0x00FF, all B = 0x0101 -> every C element = 0xFFFC (4 x 0xFFFF mod 2^16).
- Handshake: enable held high for 40 cycles after a read request -> exactly one fleg pulse, one cycle wide. Drop enable, raise with RW=1 -> write fleg the next cycle; toggling matDecide/dataInBus during COMP has no effect on the result.
- Reset asserted at COMP idx=8 -> next cycle state IDLE, no fleg, dataOut=0, A=B=0; a following read returns all zeros.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared constants, FSM state type and element access for the 4x4 matrix multiplier.
package mat_pkg;

    localparam int DATA_W = 16;
    localparam int DIM    = 4;
    localparam int MAT_W  = DIM * DIM * DATA_W;
    localparam int ROW_W  = DIM * DATA_W;
    localparam int IDX_W  = $clog2(DIM * DIM);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMP,
        ST_DONE,
        ST_HOLD
    } state_t;

    // Element [row][col] of a row-major packed matrix.
    function automatic logic [DATA_W-1:0] elem(input logic [MAT_W-1:0] mat,
                                               input logic [1:0] row,
                                               input logic [1:0] col);
        return mat[(int'(row) * DIM + int'(col)) * DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/matrix_mult_unit_if.sv
// Request/response bus between the execution engine and the matrix unit.
interface matrix_mult_unit_if;
    import mat_pkg::*;

    logic             enable;
    logic             RW;
    logic             matDecide;
    logic [MAT_W-1:0] dataInBus;
    logic [MAT_W-1:0] dataOut;
    logic             fleg;
    logic             busy;

    modport master (
        output enable, RW, matDecide, dataInBus,
        input  dataOut, fleg, busy
    );

    modport slave (
        input  enable, RW, matDecide, dataInBus,
        output dataOut, fleg, busy
    );

endinterface

// File: rtl/mat_dot4.sv
// Combinational dot product of one row and one column, truncated to DATA_W bits.
module mat_dot4
    import mat_pkg::*;
(
    input  logic [ROW_W-1:0]  i_row,
    input  logic [ROW_W-1:0]  i_col,
    output logic [DATA_W-1:0] o_sum
);

    // Multiply-accumulate across the lanes; all arithmetic wraps at DATA_W bits.
    always_comb begin
        o_sum = '0;
        for (int k = 0; k < DIM; k++) begin
            o_sum = o_sum + i_row[k*DATA_W +: DATA_W] * i_col[k*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/matrix_mult_unit.sv
// 4x4 matrix multiply stage: operand writes, then one product element per clock.
//
// state | meaning
// IDLE  | waiting for an enable request
// LOAD  | operand captured, completion pulse
// COMP  | computing element idx of A x B
// DONE  | product published to dataOut, completion pulse
// HOLD  | waiting for enable to drop before the next request
module matrix_mult_unit
    import mat_pkg::*;
(
    input  logic              clk,
    input  logic              RESET,
    matrix_mult_unit_if.slave bus
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM * DIM - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [MAT_W-1:0]  r_mat_a;
    logic [MAT_W-1:0]  r_mat_b;
    logic [MAT_W-1:0]  r_acc;
    logic [MAT_W-1:0]  r_dout;
    logic [MAT_W-1:0]  w_acc_nxt;
    logic [ROW_W-1:0]  w_row;
    logic [ROW_W-1:0]  w_col;
    logic [DATA_W-1:0] w_dot;
    logic              w_accept;

    assign w_accept = (r_state == ST_IDLE) && bus.enable;

    // State register.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a held enable parks the unit in HOLD.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.enable) w_state_nxt = bus.RW ? ST_LOAD : ST_COMP;
            ST_LOAD: w_state_nxt = ST_HOLD;
            ST_COMP: if (r_idx == IDX_LAST) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_HOLD;
            ST_HOLD: if (!bus.enable) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Select row idx/DIM of A and column idx%DIM of B for the current element.
    always_comb begin
        w_row = r_mat_a[r_idx[IDX_W-1:IDX_W/2] * ROW_W +: ROW_W];
        w_col = '0;
        for (int k = 0; k < DIM; k++) begin
            w_col[k*DATA_W +: DATA_W] = elem(r_mat_b, 2'(k), r_idx[IDX_W/2-1:0]);
        end
    end

    mat_dot4 u_dot (
        .i_row (w_row),
        .i_col (w_col),
        .o_sum (w_dot)
    );

    // Accumulator with the current element merged in, so the last element
    // reaches dataOut on the same edge as the other fifteen.
    always_comb begin
        w_acc_nxt = r_acc;
        w_acc_nxt[r_idx * DATA_W +: DATA_W] = w_dot;
    end

    // Operand capture, element accumulation and product publication.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_mat_a <= '0;
            r_mat_b <= '0;
            r_acc   <= '0;
            r_dout  <= '0;
            r_idx   <= '0;
        end else begin
            if (w_accept) begin
                r_idx <= '0;
                if (bus.RW) begin
                    if (bus.matDecide) r_mat_b <= bus.dataInBus;
                    else               r_mat_a <= bus.dataInBus;
                end
            end
            if (r_state == ST_COMP) begin
                r_acc <= w_acc_nxt;
                r_idx <= r_idx + 1'b1;
                if (r_idx == IDX_LAST) r_dout <= w_acc_nxt;
            end
        end
    end

    assign bus.dataOut = r_dout;
    assign bus.fleg    = (r_state == ST_LOAD) || (r_state == ST_DONE);
    assign bus.busy    = (r_state == ST_LOAD) || (r_state == ST_COMP) || (r_state == ST_DONE);

endmodule
